// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer.
// Holds the Bus1/Bus2 source-select codes, the ALU operation codes and the
// bit positions of the {N,Z,V,C} flags inside CCR. Both data_path and
// control_unit import this package, so the encodings live in one place.
package cpu_pkg;

    // Bus1 sources. Code 2'b11 drives zero onto the bus.
    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;

    // Bus2 sources. Code 2'b11 drives zero onto the bus.
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    // ALU operations; In1 is always B, In2 is always Bus1.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_INC = 3'b110,
        ALU_DEC = 3'b111
    } alu_op_e;

    // Flag positions inside the 4-bit CCR.
    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

endpackage

// File: rtl/data_path_if.sv
// Control/memory bundle between control_unit, data_path and memory.
// master : control side (drives strobes, selects and memory read data).
// slave  : data_path side (returns IR, CCR_Result, address, to_memory).
interface data_path_if #(
    parameter int DATA_W = 8
);
    logic              IR_Load;
    logic              MAR_Load;
    logic              PC_Load;
    logic              PC_Inc;
    logic              A_Load;
    logic              B_Load;
    logic              CCR_Load;
    logic [2:0]        ALU_Sel;
    logic [1:0]        Bus1_Sel;
    logic [1:0]        Bus2_Sel;
    logic [DATA_W-1:0] from_memory;
    logic [DATA_W-1:0] IR;
    logic [3:0]        CCR_Result;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] to_memory;

    modport master (
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        output ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
        input  IR, CCR_Result, address, to_memory
    );

    modport slave (
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
        input  ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
        output IR, CCR_Result, address, to_memory
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU of the 8-bit computer.
// Ports: In1 (B register), In2 (Bus1), ALU_Sel (alu_op_e code)
//        -> Result (truncated to DATA_W bits), NZVC (flags {N,Z,V,C}).
// C is carry-out for ADD/INC and borrow for SUB/DEC; V and C are 0 for
// the logic operations.
module alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] In1,
    input  logic [DATA_W-1:0] In2,
    input  logic [2:0]        ALU_Sel,
    output logic [DATA_W-1:0] Result,
    output logic [3:0]        NZVC
);
    localparam int              MSB = DATA_W - 1;
    localparam logic [DATA_W:0] ONE = 1;

    // One extra bit on top catches carry-out (add) or borrow (subtract of
    // zero-extended operands goes negative exactly when minuend < subtrahend).
    logic [DATA_W:0] wide;
    logic            v;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output
        // a default first, so no path can leave a value held (no latch).
        wide = '0;
        v    = 1'b0;
        case (alu_op_e'(ALU_Sel))
            ALU_ADD: begin
                wide = {1'b0, In1} + {1'b0, In2};
                v    = (In1[MSB] == In2[MSB]) && (wide[MSB] != In1[MSB]);
            end
            ALU_SUB: begin
                wide = {1'b0, In1} - {1'b0, In2};
                v    = (In1[MSB] != In2[MSB]) && (wide[MSB] != In1[MSB]);
            end
            ALU_AND: wide = {1'b0, In1 & In2};
            ALU_OR:  wide = {1'b0, In1 | In2};
            ALU_XOR: wide = {1'b0, In1 ^ In2};
            ALU_NOT: wide = {1'b0, ~In2};
            ALU_INC: begin
                wide = {1'b0, In2} + ONE;
                v    = !In2[MSB] && wide[MSB];
            end
            ALU_DEC: begin
                wide = {1'b0, In2} - ONE;
                v    = In2[MSB] && !wide[MSB];
            end
            default: wide = '0;
        endcase

        Result      = wide[MSB:0];
        NZVC        = '0;
        NZVC[CCR_N] = wide[MSB];
        NZVC[CCR_Z] = (wide[MSB:0] == '0);
        NZVC[CCR_V] = v;
        // Logic ops keep the top bit zero, so C is automatically 0 for them.
        NZVC[CCR_C] = wide[DATA_W];
    end
endmodule

// File: rtl/data_path.sv
// Register/bus datapath of the 8-bit computer.
// Holds IR, MAR, PC, A, B and CCR, the Bus1/Bus2 multiplexers and the ALU.
// Ports: Clk   - rising-edge clock for every register
//        Reset - asynchronous active-high reset
//        bus   - data_path_if.slave: load/inc strobes, ALU_Sel, Bus1_Sel,
//                Bus2_Sel, from_memory in; IR, CCR_Result, address (MAR),
//                to_memory (Bus1, combinational) out.
module data_path
    import cpu_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic       Clk,
    input  logic       Reset,
    data_path_if.slave bus
);
    localparam logic [DATA_W-1:0] PC_STEP = 1;

    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] a_q,   a_d;
    logic [DATA_W-1:0] b_q,   b_d;
    logic [3:0]        ccr_q, ccr_d;

    logic [DATA_W-1:0] bus1;
    logic [DATA_W-1:0] bus2;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_nzvc;

    // Bus1 and Bus2 sit in separate blocks: Bus2 depends on the ALU, which
    // depends on Bus1, and keeping them apart avoids a false feedback path.
    always_comb begin : bus1_mux
        case (bus.Bus1_Sel)
            BUS1_PC: bus1 = pc_q;
            BUS1_A:  bus1 = a_q;
            BUS1_B:  bus1 = b_q;
            default: bus1 = '0;
        endcase
    end

    alu #(.DATA_W(DATA_W)) u_alu (
        .In1     (b_q),
        .In2     (bus1),
        .ALU_Sel (bus.ALU_Sel),
        .Result  (alu_result),
        .NZVC    (alu_nzvc)
    );

    always_comb begin : bus2_mux
        case (bus.Bus2_Sel)
            BUS2_ALU:  bus2 = alu_result;
            BUS2_BUS1: bus2 = bus1;
            BUS2_MEM:  bus2 = bus.from_memory;
            default:   bus2 = '0;
        endcase
    end

    always_comb begin : next_state
        ir_d  = ir_q;
        mar_d = mar_q;
        pc_d  = pc_q;
        a_d   = a_q;
        b_d   = b_q;
        ccr_d = ccr_q;

        if (bus.IR_Load)  ir_d  = bus2;
        if (bus.MAR_Load) mar_d = bus2;
        if (bus.A_Load)   a_d   = bus2;
        if (bus.B_Load)   b_d   = bus2;
        if (bus.CCR_Load) ccr_d = alu_nzvc;

        // A jump target wins over the sequential increment; the add wraps.
        if (bus.PC_Load)     pc_d = bus2;
        else if (bus.PC_Inc) pc_d = pc_q + PC_STEP;
    end

    // NOTE: state registers use non-blocking '<=' so every register samples
    // the pre-edge values; all of them are plain flops and reset directly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir_q  <= '0;
            mar_q <= '0;
            pc_q  <= PC_RESET;
            a_q   <= '0;
            b_q   <= '0;
            ccr_q <= '0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ccr_q <= ccr_d;
        end
    end

    assign bus.IR         = ir_q;
    assign bus.CCR_Result = ccr_q;
    assign bus.address    = mar_q;
    assign bus.to_memory  = bus1;
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Register/bus datapath of the 8-bit computer; the responder to control_unit's load, select and increment strobes.
- Holds IR, MAR, PC, A, B and CCR, plus the two bus multiplexers and the ALU.
- Drives the memory address (MAR) and write data (Bus1).
- Feeds IR and CCR_Result back to control_unit.
- Sits between control_unit and the memory block inside the computer top level.

Parameters:
- DATA_W, 8, width of data bus and every register except CCR.
- PC_RESET, 8'h00, value loaded into PC on reset.

Ports:
Clk  input  1  system clock, all registers update on rising edge
Reset  input  1  asynchronous active-high reset
IR_Load  input  1  IR <= Bus2
MAR_Load  input  1  MAR <= Bus2
PC_Load  input  1  PC <= Bus2
PC_Inc  input  1  PC <= PC + 1
A_Load  input  1  A <= Bus2
B_Load  input  1  B <= Bus2
CCR_Load  input  1  CCR <= ALU flags
ALU_Sel  input  3  ALU operation select
Bus1_Sel  input  2  Bus1 source select
Bus2_Sel  input  2  Bus2 source select
from_memory  input  8  memory read data
IR  output  8  instruction register, to control_unit
CCR_Result  output  4  flags {N,Z,V,C} = bits [3:0], to control_unit
address  output  8  memory address = MAR
to_memory  output  8  memory write data = Bus1 (combinational)

Behaviour:
- Reset (asynchronous, active-high): IR, MAR, A, B = 8'h00; PC = PC_RESET; CCR = 4'b0000.
  - Applies immediately, mid-operation included; all loads ignored while Reset = 1.
- Bus1 (combinational): 00 = PC, 01 = A, 10 = B, 11 = 8'h00.
- Bus2 (combinational): 00 = ALU_Result, 01 = Bus1, 10 = from_memory, 11 = 8'h00.
- Register latency: a load strobe sampled high at rising edge k makes the new value visible just after edge k.
  - address, IR and CCR_Result are direct register outputs, no added delay.
- Multiple load strobes in the same cycle: every asserted register captures the same Bus2 value.
- PC update priority: PC_Load over PC_Inc; both high gives PC <= Bus2.
- PC wrap: PC_Inc at 8'hFF gives 8'h00.
- Bus2_Sel = 00 with PC_Load: PC takes ALU_Result. The ALU reads the current register values, so there is no combinational loop.
- ALU operands: In1 = B register, In2 = Bus1. Results are 8-bit, truncated.
- ALU_Sel encoding:
  - 000 ADD In1+In2
  - 001 SUB In1-In2
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT In2
  - 110 INC In2+1
  - 111 DEC In2-1
- Flags (computed every cycle, stored only when CCR_Load = 1):
  - N = result[7].
  - Z = (result == 0).
  - V = two's-complement overflow for ADD, SUB, INC, DEC; 0 for logic ops.
  - C = carry-out of bit 7 for ADD and INC.
  - C = borrow (1 when unsigned minuend < subtrahend) for SUB and DEC.
  - C = 0 for logic ops.
- CCR holds its value when CCR_Load = 0, independent of ALU activity.
- Memory writes are not gated here: to_memory and address are always driven; the write strobe goes from control_unit to memory directly.

Decomposition:
- Shared package cpu_pkg holds:
  - Bus1 select constants: BUS1_PC, BUS1_A, BUS1_B.
  - Bus2 select constants: BUS2_ALU, BUS2_BUS1, BUS2_MEM.
  - ALU_Sel op codes: ALU_ADD … ALU_DEC.
  - CCR bit indices: CCR_N = 3, CCR_Z = 2, CCR_V = 1, CCR_C = 0.
  - control_unit uses the same package.
- One sub-module, alu: purely combinational, inputs In1, In2, ALU_Sel; outputs Result[7:0] and NZVC[3:0].
- Registers and multiplexers stay in data_path.

Test Plan:
- Reset and async: assert Reset mid-cycle after loading A = 8'h55 and PC = 8'h10.
  - Required: A = 00, PC = 00, CCR = 0000 immediately, before the next Clk edge.
- Fetch path: Bus1_Sel = 00, Bus2_Sel = 01, MAR_Load, with PC = 8'h03.
  - Required: address = 03 after the edge.
  - Then from_memory = 8'h11, Bus2_Sel = 10, IR_Load with PC_Inc: IR = 11 and PC = 04.
- PC priority and wrap, part 1: PC = 8'hFF, PC_Inc only, gives PC = 00.
  - Then PC_Load and PC_Inc together with from_memory = 8'h80, Bus2_Sel = 10: PC = 80, not 81.
- ADD flags: B = 8'h7F, A = 8'h01, Bus1_Sel = 01, ALU_Sel = 000, Bus2_Sel = 00, A_Load, CCR_Load.
  - Required: A = 80, CCR_Result = 1010 (N = 1, V = 1).
- SUB zero/borrow: B = 8'h05 with A = 8'h05 gives result 00, CCR = 0100 (Z = 1, matching control_unit's BRZ test).
  - B = 8'h00 with A = 8'h01 gives result FF, CCR = 1001.
- CCR hold and store path: CCR_Load = 0 while ALU_Sel varies leaves CCR unchanged.
  - Bus1_Sel = 10 with B = 8'hAA gives to_memory = AA combinationally.
